// File: rtl/i2c_cmd_sequencer.sv
// Write-only I2C master that streams N_CMD register writes (7-bit reg, 9-bit data)
// to a codec after i_start, with per-command NACK retry and sticky error reporting.
module i2c_cmd_sequencer #(
  parameter int         N_CMD     = 10,
  parameter int         CLK_DIV   = 4,
  parameter logic [6:0] DEV_ADDR  = 7'h1A,
  parameter int         MAX_RETRY = 3
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_start,
  input  logic [16*N_CMD-1:0] i_cmd_table,
  output logic                o_busy,
  output logic                o_finished,
  output logic                o_error,
  output logic [7:0]          o_err_idx,
  output logic                o_sclk,
  inout  wire                 io_sdat,
  output logic                o_oen,
  output logic [2:0]          o_dbg_state
);
  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_BIT   = 3'd2,
    S_ACK   = 3'd3,
    S_STOP  = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t        state_q, state_d;
  logic [DW-1:0] div_q, div_d;
  logic [1:0]    qtr_q, qtr_d;
  logic [2:0]    bit_q, bit_d;
  logic [1:0]    byte_q, byte_d;
  logic [7:0]    cmd_q, cmd_d;
  logic [7:0]    retry_q, retry_d;
  logic          nack_q, nack_d;
  logic          fail_q, fail_d;
  logic          error_q, error_d;
  logic [7:0]    err_idx_q, err_idx_d;
  logic          scl_q, scl_d;
  logic          sda_q, sda_d;
  logic          oen_q, oen_d;

  logic          tick;
  logic          slot_end;
  logic [15:0]   cmd_word;
  logic [7:0]    tx_byte;

  assign tick     = (div_q == DW'(CLK_DIV - 1));
  assign slot_end = tick && (qtr_q == 2'd3);

  // Control handshake: i_start is taken only in IDLE; o_busy covers the whole run and
  // drops in the single DONE cycle where o_finished pulses. i_cmd_table must not move while o_busy.
  assign o_busy      = (state_q != S_IDLE) && (state_q != S_DONE);
  assign o_finished  = (state_q == S_DONE);
  assign o_error     = error_q;
  assign o_err_idx   = err_idx_q;
  assign o_sclk      = scl_q;
  assign o_oen       = oen_q;
  assign o_dbg_state = state_q;
  assign io_sdat     = oen_q ? sda_q : 1'bz;

  always_comb begin
    state_d   = state_q;
    div_d     = div_q;
    qtr_d     = qtr_q;
    bit_d     = bit_q;
    byte_d    = byte_q;
    cmd_d     = cmd_q;
    retry_d   = retry_q;
    nack_d    = nack_q;
    fail_d    = fail_q;
    error_d   = error_q;
    err_idx_d = err_idx_q;

    if (o_busy) begin
      div_d = tick ? '0 : div_q + 1'b1;
      if (tick) qtr_d = qtr_q + 2'd1;
    end

    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          state_d   = S_START;
          div_d     = '0;
          qtr_d     = 2'd0;
          cmd_d     = 8'd0;
          retry_d   = 8'd0;
          fail_d    = 1'b0;
          error_d   = 1'b0;
          err_idx_d = 8'd0;
        end
      end
      S_START: begin
        if (slot_end) begin
          state_d = S_BIT;
          bit_d   = 3'd0;
          byte_d  = 2'd0;
        end
      end
      S_BIT: begin
        if (slot_end) begin
          if (bit_q == 3'd7) state_d = S_ACK;
          else               bit_d   = bit_q + 3'd1;
        end
      end
      S_ACK: begin
        // Slave drives the bit while SCL is high; take it on the last clock of q2.
        if (tick && (qtr_q == 2'd2)) nack_d = io_sdat;
        if (slot_end) begin
          if (nack_q) begin
            fail_d  = 1'b1;
            state_d = S_STOP;
          end else if (byte_q == 2'd2) begin
            state_d = S_STOP;
          end else begin
            byte_d  = byte_q + 2'd1;
            bit_d   = 3'd0;
            state_d = S_BIT;
          end
        end
      end
      S_STOP: begin
        if (slot_end) begin
          if (fail_q) begin
            fail_d = 1'b0;
            if (retry_q < 8'(MAX_RETRY)) begin
              retry_d = retry_q + 8'd1;
              state_d = S_START;
            end else begin
              error_d   = 1'b1;
              err_idx_d = cmd_q;
              state_d   = S_DONE;
            end
          end else begin
            retry_d = 8'd0;
            if (cmd_q == 8'(N_CMD - 1)) begin
              state_d = S_DONE;
            end else begin
              cmd_d   = cmd_q + 8'd1;
              state_d = S_START;
            end
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign cmd_word = i_cmd_table[{cmd_d, 4'b0000} +: 16];

  always_comb begin
    case (byte_d)
      2'd0:    tx_byte = {DEV_ADDR, 1'b0};
      2'd1:    tx_byte = cmd_word[15:8];
      default: tx_byte = cmd_word[7:0];
    endcase
  end

  // Pin values are derived from the next state so the registered pins line up with state_q.
  always_comb begin
    scl_d = 1'b1;
    sda_d = 1'b1;
    oen_d = 1'b1;
    case (state_d)
      S_START: sda_d = ~qtr_d[1];
      S_BIT: begin
        scl_d = qtr_d[1];
        sda_d = tx_byte[3'd7 - bit_d];
      end
      S_ACK: begin
        scl_d = qtr_d[1];
        oen_d = 1'b0;
      end
      S_STOP: begin
        scl_d = (qtr_d != 2'd0);
        sda_d = qtr_d[1];
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= S_IDLE;
      div_q     <= '0;
      qtr_q     <= 2'd0;
      bit_q     <= 3'd0;
      byte_q    <= 2'd0;
      cmd_q     <= 8'd0;
      retry_q   <= 8'd0;
      nack_q    <= 1'b0;
      fail_q    <= 1'b0;
      error_q   <= 1'b0;
      err_idx_q <= 8'd0;
      scl_q     <= 1'b1;
      sda_q     <= 1'b1;
      oen_q     <= 1'b1;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      qtr_q     <= qtr_d;
      bit_q     <= bit_d;
      byte_q    <= byte_d;
      cmd_q     <= cmd_d;
      retry_q   <= retry_d;
      nack_q    <= nack_d;
      fail_q    <= fail_d;
      error_q   <= error_d;
      err_idx_q <= err_idx_d;
      scl_q     <= scl_d;
      sda_q     <= sda_d;
      oen_q     <= oen_d;
    end
  end

endmodule

// File: tb/tb_i2c_cmd_sequencer.sv
// Bench for i2c_cmd_sequencer: a bus decoder/slave model with an expected-byte queue,
// a table of per-quarter pin values for a CLK_DIV=1 frame, and directed multi-cycle sequences.
module tb_i2c_cmd_sequencer;
  localparam int N       = 10;
  localparam int D       = 4;
  localparam int CMD_CYC = 116 * D;

  // clock / reset
  logic clk    = 1'b0;
  logic rst_n  = 1'b0;
  logic start  = 1'b0;
  logic start2 = 1'b0;
  always #5 clk = ~clk;

  logic [16*N-1:0] cmd_tab;
  logic [15:0]     cmd_tab2;
  logic [15:0]     cmds [N] = '{16'h1E00, 16'h0C10, 16'h0E01, 16'h0A06, 16'h0812,
                                16'h0097, 16'h0297, 16'h0479, 16'h0679, 16'h1201};

  wire       busy, fin, err, scl, oen;
  wire [7:0] err_idx;
  wire [2:0] dbg;
  tri        sda;
  wire       busy2, fin2, err2, scl2, oen2;
  wire [7:0] err_idx2;
  wire [2:0] dbg2;
  tri        sda2;

  i2c_cmd_sequencer #(.N_CMD(N), .CLK_DIV(D), .DEV_ADDR(7'h1A), .MAX_RETRY(3)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_cmd_table(cmd_tab),
    .o_busy(busy), .o_finished(fin), .o_error(err), .o_err_idx(err_idx),
    .o_sclk(scl), .io_sdat(sda), .o_oen(oen), .o_dbg_state(dbg)
  );

  i2c_cmd_sequencer #(.N_CMD(1), .CLK_DIV(1), .DEV_ADDR(7'h1A), .MAX_RETRY(3)) dut2 (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start2), .i_cmd_table(cmd_tab2),
    .o_busy(busy2), .o_finished(fin2), .o_error(err2), .o_err_idx(err_idx2),
    .o_sclk(scl2), .io_sdat(sda2), .o_oen(oen2), .o_dbg_state(dbg2)
  );

  // scoreboard counters and expected byte queue
  int         n_cmp = 0;
  int         n_bad = 0;
  logic [7:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // slave model: NACKs byte nack_byte of frames nack_lo..nack_hi, ACKs everything else
  int   nack_lo   = 100;
  int   nack_hi   = -1;
  int   nack_byte = 0;
  int   cur_frame = -1;
  int   byte_idx  = 0;
  int   bit_cnt   = 0;
  logic slave_bit;
  assign slave_bit = (cur_frame >= nack_lo) && (cur_frame <= nack_hi) && (byte_idx == nack_byte);
  assign sda  = oen  ? 1'bz : slave_bit;
  assign sda2 = oen2 ? 1'bz : 1'b0;

  // bus decoder: frames on START, bits on SCL rise while the master drives
  logic       mon_en   = 1'b0;
  logic       prev_scl = 1'b1;
  logic       prev_sda = 1'b1;
  logic       prev_oen = 1'b1;
  logic [7:0] shreg    = 8'd0;
  always @(negedge clk) begin
    if (!mon_en) begin
      cur_frame = -1;
      byte_idx  = 0;
      bit_cnt   = 0;
    end else begin
      if (prev_scl && scl && prev_sda && !sda && oen) begin
        cur_frame++;
        byte_idx = 0;
        bit_cnt  = 0;
      end else if (!prev_scl && scl && oen) begin
        shreg = {shreg[6:0], sda};
        bit_cnt++;
        if (bit_cnt == 8) begin
          bit_cnt = 0;
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL byte_extra: got %02h, no byte expected", shreg);
          end else begin
            chk("byte", shreg, exp_q.pop_front());
          end
        end
      end
      if (!prev_oen && oen) byte_idx++;
    end
    prev_scl = scl;
    prev_sda = sda;
    prev_oen = oen;
  end

  // driver tasks
  task automatic push_cmd(input logic [15:0] c);
    exp_q.push_back(8'h34);
    exp_q.push_back(c[15:8]);
    exp_q.push_back(c[7:0]);
  endtask

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic mon_restart();
    mon_en = 1'b0;
    repeat (2) @(negedge clk);
    mon_en = 1'b1;
  endtask

  // counts cycles from the one after the accepting edge until o_finished
  task automatic wait_finished(input string name, input int exp_n);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
      if (n == 1) chk({name, "_busy"}, busy, 1);
    end while (!fin && n < exp_n + 50);
    chk(name, n, exp_n);
    chk({name, "_fin_busy"}, busy, 0);
  endtask

  typedef struct {
    logic [3:0] scl;
    logic [3:0] sda;
    logic       oen;
    logic       chk_sda;
  } vec_t;

  vec_t       tbl [29];
  logic [7:0] bytes2 [3];
  int         idx;
  int         n;
  logic       reached;

  initial begin
    for (int i = 0; i < N; i++) cmd_tab[16*i +: 16] = cmds[i];
    cmd_tab2 = 16'h0097;

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_sclk", scl, 1);
    chk("rst_oen", oen, 1);
    chk("rst_sdat", sda, 1);
    chk("rst_busy", busy, 0);
    chk("rst_fin", fin, 0);
    chk("rst_err", err, 0);
    chk("rst_err_idx", err_idx, 0);
    chk("rst_dbg", dbg, 0);
    chk("rst_dbg2", dbg2, 0);
    @(negedge clk) rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // single 0x0097 frame at CLK_DIV=1, one quarter per cycle
    bytes2[0] = 8'b0011_0100;
    bytes2[1] = 8'b0000_0000;
    bytes2[2] = 8'b1001_0111;
    tbl[0] = '{4'b1111, 4'b1100, 1'b1, 1'b1};
    idx = 1;
    for (int by = 0; by < 3; by++) begin
      for (int b = 7; b >= 0; b--) begin
        tbl[idx] = '{4'b0011, {4{bytes2[by][b]}}, 1'b1, 1'b1};
        idx++;
      end
      tbl[idx] = '{4'b0011, 4'b0000, 1'b0, 1'b0};
      idx++;
    end
    tbl[28] = '{4'b0111, 4'b0011, 1'b1, 1'b1};
    @(negedge clk) start2 = 1'b1;
    @(posedge clk);
    #1 start2 = 1'b0;
    for (int s = 0; s < 29; s++) begin
      for (int q = 0; q < 4; q++) begin
        @(negedge clk);
        chk("t2_scl", scl2, tbl[s].scl[3-q]);
        chk("t2_oen", oen2, tbl[s].oen);
        if (tbl[s].chk_sda) chk("t2_sda", sda2, tbl[s].sda[3-q]);
      end
    end
    @(negedge clk);
    chk("t2_fin", fin2, 1);
    chk("t2_err", err2, 0);

    // all ACK, full ten-command run
    mon_restart();
    for (int i = 0; i < N; i++) push_cmd(cmds[i]);
    pulse_start();
    wait_finished("t1_lat", 1 + N * CMD_CYC);
    chk("t1_err", err, 0);
    chk("t1_left", exp_q.size(), 0);
    chk("t1_frames", cur_frame, N - 1);

    // one NACK on cmd3 data byte: cmd3 is re-sent once
    mon_restart();
    nack_lo = 3; nack_hi = 3; nack_byte = 2;
    for (int i = 0; i < 4; i++) push_cmd(cmds[i]);
    for (int i = 3; i < N; i++) push_cmd(cmds[i]);
    pulse_start();
    wait_finished("t3_lat", 1 + (N + 1) * CMD_CYC);
    chk("t3_err", err, 0);
    chk("t3_left", exp_q.size(), 0);
    chk("t3_frames", cur_frame, N);
    nack_lo = 100; nack_hi = -1;

    // cmd5 address always NACKed: four 11-slot attempts, then abort
    mon_restart();
    nack_lo = 5; nack_hi = 8; nack_byte = 0;
    for (int i = 0; i < 5; i++) push_cmd(cmds[i]);
    repeat (4) exp_q.push_back(8'h34);
    pulse_start();
    wait_finished("t4_lat", 1 + 5 * CMD_CYC + 4 * 44 * D);
    chk("t4_err", err, 1);
    chk("t4_err_idx", err_idx, 5);
    chk("t4_left", exp_q.size(), 0);
    chk("t4_frames", cur_frame, 8);
    @(negedge clk);
    chk("t4_fin_pulse", fin, 0);
    chk("t4_err_sticky", err, 1);
    nack_lo = 100; nack_hi = -1;

    // reset in the middle of cmd2 register byte, then a clean restart
    mon_restart();
    for (int i = 0; i < N; i++) push_cmd(cmds[i]);
    pulse_start();
    @(negedge clk);
    chk("t5_err_clr", err, 0);
    reached = 1'b0;
    for (int i = 0; i < 3 * CMD_CYC && !reached; i++) begin
      @(negedge clk);
      if (cur_frame == 2 && byte_idx == 1 && bit_cnt == 3) reached = 1'b1;
    end
    chk("t5_reach", reached, 1);
    rst_n = 1'b0;
    #1;
    chk("t5_sclk", scl, 1);
    chk("t5_oen", oen, 1);
    chk("t5_sdat", sda, 1);
    chk("t5_busy", busy, 0);
    chk("t5_fin", fin, 0);
    mon_en = 1'b0;
    exp_q.delete();
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);
    mon_restart();
    for (int i = 0; i < N; i++) push_cmd(cmds[i]);
    pulse_start();
    wait_finished("t5_lat", 1 + N * CMD_CYC);
    chk("t5_left", exp_q.size(), 0);
    chk("t5_frames", cur_frame, N - 1);

    // start pulsed mid-run (ignored), then held high through DONE; DONE is followed
    // by one IDLE cycle that accepts the held start
    mon_restart();
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < N; i++) push_cmd(cmds[i]);
    pulse_start();
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (n == 2000) start = 1'b1;
      if (n == 2001) start = 1'b0;
      if (n == 2002) chk("t6_busy_mid", busy, 1);
      if (n == 3000) start = 1'b1;
    end while (!fin && n < 1 + N * CMD_CYC + 50);
    chk("t6_lat1", n, 1 + N * CMD_CYC);
    @(negedge clk);
    chk("t6_idle_busy", busy, 0);
    chk("t6_idle_fin", fin, 0);
    @(posedge clk);
    #1 start = 1'b0;
    wait_finished("t6_lat2", 1 + N * CMD_CYC);
    chk("t6_left", exp_q.size(), 0);
    chk("t6_frames", cur_frame, 2 * N - 1);

    // final report
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
